// File: rtl/volume_ctrl.sv
// volume_ctrl: push-button front end for the `volume` block.
//
// Turns two raw, bouncing, asynchronous buttons into single-cycle up/down
// command pulses, keeps a shadow copy of the attenuation level and refuses
// to issue a command that would push the level past 0 or MAX_LEVEL_P.
//
// Ports:
//   clk_i       system clock (same domain as `volume`)
//   reset_ni    asynchronous active-low reset
//   btn_up_i    raw up button, active-high, asynchronous, may bounce
//   btn_down_i  raw down button, active-high, asynchronous, may bounce
//   up_o        one-cycle pulse to volume.up_i
//   down_o      one-cycle pulse to volume.down_i
//   level_o     shadow level, equals the `volume` shift amount
//   both_o      high while both debounced buttons are pressed
//
// Build option:
//   VOLUME_CTRL_AUTOREPEAT_EN  when defined, holding a button repeats the
//   command (first repeat after REPEAT_DELAY_P cycles, then every
//   REPEAT_RATE_P cycles). When undefined, one pulse per press.
module volume_ctrl #(
  parameter int DEBOUNCE_CYCLES_P = 16,
  parameter int REPEAT_DELAY_P    = 64,
  parameter int REPEAT_RATE_P     = 16,
  parameter int MAX_LEVEL_P       = 7
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               btn_up_i,
  input  logic                               btn_down_i,
  output logic                               up_o,
  output logic                               down_o,
  output logic [$clog2(MAX_LEVEL_P+1)-1:0]   level_o,
  output logic                               both_o
);

  localparam int LvlW = $clog2(MAX_LEVEL_P + 1);
  localparam int DbW  = $clog2(DEBOUNCE_CYCLES_P + 1);
  localparam logic [LvlW-1:0] LvlMax = LvlW'(MAX_LEVEL_P);
  localparam logic [DbW-1:0]  DbLast = DbW'(DEBOUNCE_CYCLES_P - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
  localparam logic [1:0] S_REPEAT = 2'd2;
`endif
  localparam logic [1:0] S_LOCK   = 2'd3;

  // bit 0 = up button, bit 1 = down button
  logic [1:0] raw;
  logic [1:0] deb;
  assign raw = {btn_down_i, btn_up_i};

  // Per-button 2-flop synchroniser + debounce. The counter only runs while
  // the synchronised input disagrees with the accepted state; the change is
  // accepted on the DEBOUNCE_CYCLES_P-th consecutive disagreeing cycle.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic           s1_q, s2_q;
    logic           deb_q, deb_d;
    logic [DbW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (s2_q != deb_q) begin
        if (cnt_q == DbLast) deb_d = s2_q;
        else                 cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= raw[i];
        s2_q  <= s1_q;
        deb_q <= deb_d;
        cnt_q <= cnt_d;
      end
    end

    assign deb[i] = deb_q;
  end

  logic deb_up, deb_dn;
  assign deb_up = deb[0];
  assign deb_dn = deb[1];

  // ---------------------------------------------------------------------
  // Press FSM
  // ---------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic            dir_q, dir_d;     // 0 = up held, 1 = down held
  logic            fire_up, fire_dn;
  logic            held, other;
  logic            up_q, up_d, dn_q, dn_d;
  logic [LvlW-1:0] level_q, level_d;

`ifdef VOLUME_CTRL_AUTOREPEAT_EN
  localparam int RptMax = (REPEAT_DELAY_P > REPEAT_RATE_P) ? REPEAT_DELAY_P : REPEAT_RATE_P;
  localparam int RptW   = $clog2(RptMax);
  localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY_P - 1);
  localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE_P - 1);
  logic [RptW-1:0] rpt_q, rpt_d;
`endif

  assign held  = dir_q ? deb_dn : deb_up;
  assign other = dir_q ? deb_up : deb_dn;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    fire_up = 1'b0;
    fire_dn = 1'b0;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (deb_up && deb_dn) begin
          state_d = S_LOCK;
        end else if (deb_up || deb_dn) begin
          fire_up = deb_up;
          fire_dn = deb_dn;
          dir_d   = deb_dn;
          state_d = S_HOLD;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end
      end
      S_HOLD: begin
        if (!held)      state_d = S_IDLE;
        else if (other) state_d = S_LOCK;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
        else if (rpt_q == DelayLast) begin
          fire_up = !dir_q;
          fire_dn = dir_q;
          rpt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
`endif
      end
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
      S_REPEAT: begin
        if (!held)      state_d = S_IDLE;
        else if (other) state_d = S_LOCK;
        else if (rpt_q == RateLast) begin
          fire_up = !dir_q;
          fire_dn = dir_q;
          rpt_d   = '0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
`endif
      S_LOCK: begin
        // Only a full release re-arms; releasing one button must not
        // look like a fresh press of the other.
        if (!deb_up && !deb_dn) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses at a bound are dropped but the FSM has already advanced, so a
  // held button keeps its repeat cadence.
  always_comb begin
    up_d    = fire_up && (level_q != LvlMax);
    dn_d    = fire_dn && (level_q != '0);
    level_d = level_q;
    if (up_d)      level_d = level_q + 1'b1;
    else if (dn_d) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      level_q <= '0;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      level_q <= level_d;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign up_o    = up_q;
  assign down_o  = dn_q;
  assign level_o = level_q;
  assign both_o  = deb_up & deb_dn;

endmodule

// File: tb/tb_volume_ctrl.sv
// Testbench for volume_ctrl (DEBOUNCE=4, REPEAT_DELAY=8, REPEAT_RATE=4, MAX=7).
// Every cycle is compared against a reference model built from the
// behavioural rules: a raw-sample delay line, a "last N samples all
// disagree" debounce window and a time-since-press repeat schedule.
module tb_volume_ctrl;
  localparam int DB   = 4;
  localparam int DLY  = 8;
  localparam int RATE = 4;
  localparam int MAXL = 7;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b1;
  logic       btn_up_i = 1'b0;
  logic       btn_down_i = 1'b0;
  logic       up_o, down_o, both_o;
  logic [2:0] level_o;

  int checks = 0;
  int errors = 0;

  volume_ctrl #(
    .DEBOUNCE_CYCLES_P(DB),
    .REPEAT_DELAY_P   (DLY),
    .REPEAT_RATE_P    (RATE),
    .MAX_LEVEL_P      (MAXL)
  ) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .btn_up_i  (btn_up_i),
    .btn_down_i(btn_down_i),
    .up_o      (up_o),
    .down_o    (down_o),
    .level_o   (level_o),
    .both_o    (both_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_HELD = 1, M_LOCK = 2;
  bit m_d1u, m_d2u, m_d1d, m_d2d;
  bit m_win_u[DB];
  bit m_win_d[DB];
  bit m_deb_u, m_deb_d;
  int m_mode, m_el, m_level;
  bit m_dir, m_up, m_dn, m_both;

  int cnt_up, cnt_dn;
  bit both_seen;

  task automatic model_clear();
    m_d1u = 0; m_d2u = 0; m_d1d = 0; m_d2d = 0;
    for (int i = 0; i < DB; i++) begin m_win_u[i] = 0; m_win_d[i] = 0; end
    m_deb_u = 0; m_deb_d = 0;
    m_mode = M_IDLE; m_el = 0; m_level = 0; m_dir = 0;
    m_up = 0; m_dn = 0; m_both = 0;
  endtask

  task automatic model_edge(input bit u, input bit d);
    bit su, sd, ou, od, fu, fd, held, other, flip_u, flip_d;
    su = m_d2u; sd = m_d2d;
    m_d2u = m_d1u; m_d1u = u;
    m_d2d = m_d1d; m_d1d = d;
    ou = m_deb_u; od = m_deb_d;
    for (int i = DB - 1; i > 0; i--) begin
      m_win_u[i] = m_win_u[i-1];
      m_win_d[i] = m_win_d[i-1];
    end
    m_win_u[0] = su; m_win_d[0] = sd;
    flip_u = 1; flip_d = 1;
    for (int i = 0; i < DB; i++) begin
      if (m_win_u[i] == m_deb_u) flip_u = 0;
      if (m_win_d[i] == m_deb_d) flip_d = 0;
    end
    if (flip_u) m_deb_u = !m_deb_u;
    if (flip_d) m_deb_d = !m_deb_d;
    fu = 0; fd = 0;
    held  = m_dir ? od : ou;
    other = m_dir ? ou : od;
    case (m_mode)
      M_IDLE: begin
        if (ou && od) m_mode = M_LOCK;
        else if (ou || od) begin
          m_dir = od; m_el = 0; m_mode = M_HELD; fu = ou; fd = od;
        end
      end
      M_HELD: begin
        if (!held) m_mode = M_IDLE;
        else if (other) m_mode = M_LOCK;
        else begin
          m_el++;
          if (AUTO && m_el >= DLY && ((m_el - DLY) % RATE) == 0) begin
            fu = !m_dir; fd = m_dir;
          end
        end
      end
      default: if (!ou && !od) m_mode = M_IDLE;
    endcase
    m_up = fu && (m_level < MAXL);
    m_dn = fd && (m_level > 0);
    m_level = m_level + int'(m_up) - int'(m_dn);
    m_both = m_deb_u && m_deb_d;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle (called at a negedge), step the model at the posedge,
  // compare at the following negedge.
  task automatic step(input bit u, input bit d);
    btn_up_i = u; btn_down_i = d;
    @(posedge clk_i);
    model_edge(u, d);
    @(negedge clk_i);
    check("up_o", up_o, m_up);
    check("down_o", down_o, m_dn);
    check("level_o", level_o, m_level);
    check("both_o", both_o, m_both);
    check("up_down_exclusive", up_o & down_o, 0);
    cnt_up += int'(up_o);
    cnt_dn += int'(down_o);
    if (both_o) both_seen = 1;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    #1;
    check("reset up_o", up_o, 0);
    check("reset down_o", down_o, 0);
    check("reset level_o", level_o, 0);
    check("reset both_o", both_o, 0);
    model_clear();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  typedef struct {
    bit up; bit dn; bit bounce; int hold;
    int exp_up; int exp_dn; int exp_lvl; bit exp_both;
  } vec_t;
  vec_t tv[9];

  initial begin
    tv[0] = '{0, 1, 0, 5,  0, 0, 0, 0};                          // down at level 0
    tv[1] = '{1, 0, 0, 5,  1, 0, 1, 0};
    tv[2] = '{1, 0, 0, 5,  1, 0, 2, 0};
    tv[3] = '{1, 0, 0, 5,  1, 0, 3, 0};
    tv[4] = '{0, 1, 1, 5,  0, 1, 2, 0};                          // bounce then hold
    tv[5] = '{1, 0, 0, 40, AUTO ? 5 : 1, 0, AUTO ? 7 : 3, 0};    // long hold up
    tv[6] = '{1, 0, 0, 5,  AUTO ? 0 : 1, 0, AUTO ? 7 : 4, 0};    // at/near top
    tv[7] = '{0, 1, 0, 40, 0, AUTO ? 7 : 1, AUTO ? 0 : 3, 0};    // long hold down
    tv[8] = '{1, 1, 0, 10, 0, 0, AUTO ? 0 : 3, 1};               // simultaneous

    model_clear();
    cnt_up = 0; cnt_dn = 0; both_seen = 0;
    #2;
    do_reset();

    // First-press latency: pulse only after edge 3+DB = 7.
    for (int k = 1; k <= 16; k++) begin
      step(k <= 5, 1'b0);
      check($sformatf("latency up_o edge %0d", k), up_o, (k == 7) ? 1 : 0);
    end
    check("latency level", level_o, 1);

    // Overlap: up, then down while up held, release up, release down.
    cnt_up = 0; cnt_dn = 0; both_seen = 0;
    repeat (4)  step(1, 0);
    repeat (12) step(1, 1);
    repeat (12) step(0, 1);
    repeat (16) step(0, 0);
    check("overlap up pulses", cnt_up, 1);
    check("overlap down pulses", cnt_dn, 0);
    check("overlap both seen", both_seen, 1);
    check("overlap both after", both_o, 0);
    check("overlap level", level_o, 2);

    // Reset while the button is held (mid-repeat with autorepeat).
    repeat (24) step(1, 0);
    #2;
    do_reset();
    cnt_up = 0; cnt_dn = 0;
    repeat (8)  step(1, 0);
    repeat (16) step(0, 0);
    check("post-reset up pulses", cnt_up, 1);
    check("post-reset level", level_o, 1);

    // Table-driven presses from level 0.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cnt_up = 0; cnt_dn = 0; both_seen = 0;
      if (tv[i].bounce) begin
        step(tv[i].up, tv[i].dn); step(0, 0);
        step(tv[i].up, tv[i].dn); step(0, 0);
      end
      repeat (tv[i].hold) step(tv[i].up, tv[i].dn);
      repeat (16) step(0, 0);
      check($sformatf("vec%0d up pulses", i), cnt_up, tv[i].exp_up);
      check($sformatf("vec%0d down pulses", i), cnt_dn, tv[i].exp_dn);
      check($sformatf("vec%0d level", i), level_o, tv[i].exp_lvl);
      check($sformatf("vec%0d both seen", i), both_seen, tv[i].exp_both);
    end

    // Random button activity against the model.
    for (int p = 0; p < 250; p++) begin
      bit u, d;
      int len;
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
      repeat (len) step(u, d);
    end
    repeat (16) step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
